div_sequencer: RTL



---
 rtl/div_sequencer_pkg.sv | 23 ++
 rtl/div_step.sv | 28 ++
 rtl/div_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU sequencer.
// Decode maps the EXE_DIV(U)_OP codes onto start/signed_div.
package div_sequencer_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // EX-stage operation codes that select the divider path
    localparam logic [5:0] EXE_DIV_OP  = 6'b011010;
    localparam logic [5:0] EXE_DIVU_OP = 6'b011011;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_DZERO = 2'd1,
        DIV_BUSY  = 2'd2,
        DIV_DONE  = 2'd3
    } div_state_e;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] rem;
        logic [DIV_WIDTH-1:0] quot;
    } div_result_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on the shared {remainder, quotient} register.
// The register is shifted left one place, then the divisor is trial-subtracted from the upper part.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH:0]  i_sr,
    input  logic [WIDTH-1:0]  i_divisor,
    output logic [2*WIDTH:0]  o_next_c
);

    logic [2*WIDTH:0] w_shift;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    // A set MSB before the shift means the shifted remainder already exceeds any divisor
    always_comb begin
        w_shift  = {i_sr[2*WIDTH-1:0], 1'b0};
        w_rem    = w_shift[2*WIDTH:WIDTH];
        w_ge     = i_sr[2*WIDTH] | (w_rem >= {1'b0, i_divisor});
        w_diff   = w_rem - {1'b0, i_divisor};
        o_next_c = w_shift;
        if (w_ge) begin
            o_next_c = {w_diff, w_shift[WIDTH-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// DIV/DIVU controller: latches operands, runs WIDTH restoring steps, applies the
// signed fix-up and presents {remainder, quotient} for the HI/LO write.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               annul,
    output logic               stall_o,
    output logic               valid_o,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned SR_W  = 2 * WIDTH + 1;

    div_state_e          r_state;
    div_state_e          w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [SR_W-1:0]     r_sr;
    logic [WIDTH-1:0]    r_divisor;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [2*WIDTH-1:0]  r_result;
    logic                r_valid;

    logic [SR_W-1:0]     w_step_sr;
    logic [2*WIDTH-1:0]  w_final;
    logic [WIDTH-1:0]    w_quot;
    logic [WIDTH-1:0]    w_rem;
    logic [WIDTH-1:0]    w_quot_fix;
    logic [WIDTH-1:0]    w_rem_fix;
    logic [WIDTH-1:0]    w_abs_a;
    logic [WIDTH-1:0]    w_abs_b;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_dzero;
    logic                w_load;
    logic                w_last;

    assign valid_o = r_valid;
    assign result  = r_result;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_sr      (r_sr),
        .i_divisor (r_divisor),
        .o_next_c  (w_step_sr)
    );

    // Operand magnitudes and sign bookkeeping for the signed fix-up
    always_comb begin
        w_a_neg = signed_div & opa[WIDTH-1];
        w_b_neg = signed_div & opb[WIDTH-1];
        w_abs_a = w_a_neg ? WIDTH'(~opa + WIDTH'(1)) : opa;
        w_abs_b = w_b_neg ? WIDTH'(~opb + WIDTH'(1)) : opb;
        w_dzero = (opb == '0);
        w_last  = (r_cnt == CNT_W'(WIDTH - 1));
    end

    // The step output is the final value when leaving BUSY; DZERO preloads its answer into r_sr
    always_comb begin
        w_final    = (r_state == DIV_BUSY) ? w_step_sr[2*WIDTH-1:0] : r_sr[2*WIDTH-1:0];
        w_quot     = w_final[WIDTH-1:0];
        w_rem      = w_final[2*WIDTH-1:WIDTH];
        w_quot_fix = r_neg_q ? WIDTH'(~w_quot + WIDTH'(1)) : w_quot;
        w_rem_fix  = r_neg_r ? WIDTH'(~w_rem + WIDTH'(1)) : w_rem;
    end

    // Next-state and stall request; annul overrides everything
    always_comb begin
        w_state_next = r_state;
        stall_o      = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (start) begin
                    stall_o      = 1'b1;
                    w_state_next = w_dzero ? DIV_DZERO : DIV_BUSY;
                end
            end
            DIV_DZERO: begin
                stall_o      = 1'b1;
                w_state_next = DIV_DONE;
            end
            DIV_BUSY: begin
                stall_o = 1'b1;
                if (w_last) begin
                    w_state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                w_state_next = DIV_IDLE;
            end
            default: begin
                w_state_next = DIV_IDLE;
            end
        endcase
        if (annul) begin
            stall_o      = 1'b0;
            w_state_next = DIV_IDLE;
        end
    end

    assign w_load = (r_state == DIV_IDLE) && (w_state_next != DIV_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch, iteration counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_sr      <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= (w_state_next == DIV_DONE);
            if (w_state_next == DIV_DONE) begin
                r_result <= {w_rem_fix, w_quot_fix};
            end
            if (w_load) begin
                r_cnt     <= '0;
                r_divisor <= w_abs_b;
                if (w_dzero) begin
                    r_sr    <= {1'b0, opa, {WIDTH{1'b1}}};
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end else begin
                    r_sr    <= {(WIDTH + 1)'(0), w_abs_a};
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                end
            end else if (r_state == DIV_BUSY) begin
                r_sr  <= w_step_sr;
                r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
            end
        end
    end

endmodule
